// File: rtl/urllc_sender_if.sv
// ---------------------------------------------------------------------------
// urllc_sender_if
// Bundles the sender's ADC, DAC and sync signals.
//   sender_sync_in  : transmit enable (asynchronous to the sender clock)
//   sender_sync_out : one-cycle frame strobe on the first cycle of a frame
//   sender_ad       : 8-bit unsigned ADC sample
//   sender_da       : 8-bit unsigned DAC sample, midscale 8'h80
// Modports:
//   master : the transmitter. It drives the DAC and the strobe.
//   slave  : the surrounding front end. It drives the enable and the ADC word.
// ---------------------------------------------------------------------------
interface urllc_sender_if;
  logic       sender_sync_in;
  logic       sender_sync_out;
  logic [7:0] sender_ad;
  logic [7:0] sender_da;

  modport master (
    input  sender_sync_in,
    input  sender_ad,
    output sender_sync_out,
    output sender_da
  );

  modport slave (
    output sender_sync_in,
    output sender_ad,
    input  sender_sync_out,
    input  sender_da
  );
endinterface

// File: rtl/urllc_sender.sv
// ---------------------------------------------------------------------------
// urllc_sender
// Baseband BPSK transmitter for the URLLC link. Each frame samples the ADC
// word once and sends an 18-bit frame: the sync word (MSB first), the data
// byte (MSB first), an even parity bit and a stop bit. Each bit is one full
// sine period of BIT_CYCLES samples. A 1 is sent in phase and a 0 is sent
// inverted about midscale.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : urllc_sender_if.master (sync in/out, ADC in, DAC out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | DAC parked at midscale and waiting for the synchronised enable
// FRAME | sending bit r_bit, carrier phase r_phase
// ---------------------------------------------------------------------------
module urllc_sender #(
  parameter int          BIT_CYCLES = 20,     // carrier table is built for 20
  parameter logic [7:0]  SYNC_WORD  = 8'h7E,
  parameter int          AMP        = 100     // must stay <= 127
) (
  input  logic           clock,
  input  logic           reset,
  urllc_sender_if.master bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  localparam logic [4:0] PHASE_LAST = 5'(BIT_CYCLES - 1);
  localparam logic [4:0] BIT_LAST   = 5'd17;
  localparam logic [7:0] MIDSCALE   = 8'h80;

  // Quarter-wave amplitudes, round(AMP*sin(k*18deg)) for k = 0..5.
  // sin values are held in units of 1/1000.
  localparam logic [7:0] A1 = 8'((AMP * 309 + 500) / 1000);
  localparam logic [7:0] A2 = 8'((AMP * 588 + 500) / 1000);
  localparam logic [7:0] A3 = 8'((AMP * 809 + 500) / 1000);
  localparam logic [7:0] A4 = 8'((AMP * 951 + 500) / 1000);
  localparam logic [7:0] A5 = 8'(AMP);

  logic       r_sync1;
  logic       r_sync2;
  logic [0:0] r_state;
  logic [4:0] r_bit;
  logic [4:0] r_phase;
  logic [7:0] r_data;
  logic [7:0] r_da;
  logic       r_sync_out;

  logic       w_en;
  logic       w_start;
  logic [0:0] w_state_nxt;
  logic [4:0] w_bit_nxt;
  logic [4:0] w_phase_nxt;
  logic [7:0] w_data_nxt;
  logic       w_sym;
  logic [7:0] w_mag;
  logic       w_up;
  logic [7:0] w_sample;
  logic [7:0] w_da_nxt;

  // Maps phase 0..19 onto the first quarter wave (index 0..5).
  function automatic logic [2:0] quarter_idx(input logic [4:0] k);
    if (k <= 5'd5)       return k[2:0];
    else if (k <= 5'd10) return 3'(5'd10 - k);
    else if (k <= 5'd15) return 3'(k - 5'd10);
    else                 return 3'(5'd20 - k);
  endfunction

  function automatic logic [7:0] quarter_amp(input logic [2:0] q);
    case (q)
      3'd0:    return 8'd0;
      3'd1:    return A1;
      3'd2:    return A2;
      3'd3:    return A3;
      3'd4:    return A4;
      default: return A5;
    endcase
  endfunction

  // Symbol carried by frame bit b, given the latched data byte d.
  function automatic logic frame_symbol(input logic [4:0] b, input logic [7:0] d);
    if (b < 5'd8)       return SYNC_WORD[3'd7 - b[2:0]];
    else if (b < 5'd16) return d[3'd7 - b[2:0]];
    else if (b == 5'd16) return ^d;
    else                return 1'b1;
  endfunction

  assign w_en = r_sync2;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_phase_nxt = r_phase;
    w_data_nxt  = r_data;
    w_start     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_en) w_start = 1'b1;
      end
      default: begin
        if (r_phase == PHASE_LAST) begin
          w_phase_nxt = 5'd0;
          if (r_bit == BIT_LAST) begin
            // Back-to-back frames when the enable is still high, so the
            // frame period stays exactly 18 * BIT_CYCLES.
            if (w_en) begin
              w_start = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_bit_nxt   = 5'd0;
            end
          end else begin
            w_bit_nxt = r_bit + 5'd1;
          end
        end else begin
          w_phase_nxt = r_phase + 5'd1;
        end
      end
    endcase

    if (w_start) begin
      w_state_nxt = ST_FRAME;
      w_bit_nxt   = 5'd0;
      w_phase_nxt = 5'd0;
      w_data_nxt  = bus.sender_ad;
    end
  end

  // The DAC register is loaded from the next-state bit and phase. This keeps
  // the output aligned with the strobe, with no extra pipeline stage.
  assign w_sym    = frame_symbol(w_bit_nxt, w_data_nxt);
  assign w_mag    = quarter_amp(quarter_idx(w_phase_nxt));
  assign w_up     = w_sym ? (w_phase_nxt < 5'd10) : !(w_phase_nxt < 5'd10);
  assign w_sample = w_up ? (MIDSCALE + w_mag) : (MIDSCALE - w_mag);
  assign w_da_nxt = (w_state_nxt == ST_FRAME) ? w_sample : MIDSCALE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= ST_IDLE;
      r_bit      <= 5'd0;
      r_phase    <= 5'd0;
      r_data     <= 8'd0;
      r_da       <= MIDSCALE;
      r_sync_out <= 1'b0;
    end else begin
      r_sync1    <= bus.sender_sync_in;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_bit      <= w_bit_nxt;
      r_phase    <= w_phase_nxt;
      r_data     <= w_data_nxt;
      r_da       <= w_da_nxt;
      r_sync_out <= w_start;
    end
  end

  assign bus.sender_da       = r_da;
  assign bus.sender_sync_out = r_sync_out;

endmodule

// File: tb/tb_urllc_sender.sv
// ---------------------------------------------------------------------------
// tb_urllc_sender
// Directed bench for urllc_sender. Expected DAC values are taken by hand from
// the carrier table: 28 for bit 0 at phase 5, 228 for bit 1 at phase 5, and
// 128 at phase 0.
// ---------------------------------------------------------------------------
module tb_urllc_sender;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  urllc_sender_if bus ();

  urllc_sender dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_frame(input int limit, output bit found, output int edges);
    found = 1'b0;
    edges = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      edges++;
      if (bus.sender_sync_out === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL frame_start: sync_out never pulsed within %0d cycles (required one pulse)", limit);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset = 1'b1;
    bus.sender_sync_in = 1'b1;
    bus.sender_ad = 8'h55;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.sender_da !== 8'h80 || bus.sender_sync_out !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL reset_hold: %0d cycles with da/sync_out off reset value (required 0), last da=%h sync=%b",
               bad, bus.sender_da, bus.sender_sync_out);
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    bus.sender_sync_in = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (bus.sender_da !== 8'h80 || bus.sender_sync_out !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL idle: %0d cycles off idle output (required 0), last da=%h sync=%b",
               bad, bus.sender_da, bus.sender_sync_out);
    end
  endtask

  task automatic test_single_frame();
    int          offs [8] = '{0, 5, 25, 145, 165, 205, 325, 345};
    logic [7:0]  exps [8] = '{8'd128, 8'd28, 8'd228, 8'd28, 8'd28, 8'd228, 8'd228, 8'd228};
    bit          found;
    int          edges;
    int          pulses;
    int          idle_bad;
    bus.sender_ad = 8'h20;
    bus.sender_sync_in = 1'b1;
    wait_frame(10, found, edges);
    pulses = 1;
    idle_bad = 0;
    for (int off = 0; off < 400; off++) begin
      if (off > 0) begin
        tick();
        if (bus.sender_sync_out === 1'b1) pulses++;
      end
      if (off == 100) bus.sender_sync_in = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (off == offs[j]) begin
          tests_run++;
          if (bus.sender_da !== exps[j]) begin
            tests_failed++;
            $display("FAIL single_da@F+%0d: got %0d required %0d", off, bus.sender_da, exps[j]);
          end
        end
      end
      if (off >= 360 && bus.sender_da !== 8'h80) idle_bad++;
    end
    tests_run++;
    if (pulses !== 1) begin
      tests_failed++;
      $display("FAIL single_pulses: got %0d sync_out pulses required 1", pulses);
    end
    tests_run++;
    if (idle_bad !== 0) begin
      tests_failed++;
      $display("FAIL single_after_frame: %0d cycles after F+360 off midscale (required 0)", idle_bad);
    end
  endtask

  task automatic test_continuous();
    logic [15:0] par_tab;
    logic [7:0]  cur;
    logic [7:0]  exp_da;
    logic        exp_bit;
    bit          found;
    int          edges;
    int          sync_bad;
    par_tab = 16'h9669;  // parity of 8'h20+i stored at bit i
    sync_bad = 0;
    bus.sender_ad = 8'h20;
    bus.sender_sync_in = 1'b1;
    wait_frame(10, found, edges);
    for (int f = 0; f < 16; f++) begin
      cur = 8'h20 + 8'(f);
      for (int off = 0; off < 360; off++) begin
        if (!(f == 0 && off == 0)) tick();
        if (bus.sender_sync_out !== (off == 0)) sync_bad++;
        // The ADC word changes mid-frame and must only show up in the next frame.
        if (off == 100) bus.sender_ad = 8'h21 + 8'(f);
        for (int b = 8; b <= 16; b++) begin
          if (off == 20 * b + 5) begin
            exp_bit = (b < 16) ? cur[15 - b] : par_tab[f];
            exp_da  = exp_bit ? 8'd228 : 8'd28;
            tests_run++;
            if (bus.sender_da !== exp_da) begin
              tests_failed++;
              $display("FAIL cont_ad%h_bit%0d: got %0d required %0d", cur, b, bus.sender_da, exp_da);
            end
          end
        end
      end
    end
    tests_run++;
    if (sync_bad !== 0) begin
      tests_failed++;
      $display("FAIL cont_sync_period: %0d cycles with sync_out off the 360-cycle pattern (required 0)", sync_bad);
    end
    bus.sender_sync_in = 1'b0;
    for (int i = 0; i < 420; i++) tick();
  endtask

  task automatic test_mid_disable();
    int          offs [6] = '{5, 25, 205, 325, 345, 359};
    logic [7:0]  exps [6] = '{8'd28, 8'd228, 8'd28, 8'd28, 8'd228, 8'd97};
    bit          found;
    int          edges;
    int          tail_bad;
    tail_bad = 0;
    bus.sender_ad = 8'h5A;
    bus.sender_sync_in = 1'b1;
    wait_frame(10, found, edges);
    for (int off = 1; off < 800; off++) begin
      tick();
      if (off == 50) bus.sender_sync_in = 1'b0;
      for (int j = 0; j < 6; j++) begin
        if (off == offs[j]) begin
          tests_run++;
          if (bus.sender_da !== exps[j]) begin
            tests_failed++;
            $display("FAIL disable_da@F+%0d: got %0d required %0d", off, bus.sender_da, exps[j]);
          end
        end
      end
      if (bus.sender_sync_out !== 1'b0) tail_bad++;
      if (off >= 360 && bus.sender_da !== 8'h80) tail_bad++;
    end
    tests_run++;
    if (tail_bad !== 0) begin
      tests_failed++;
      $display("FAIL disable_tail: %0d bad cycles (extra sync_out or non-midscale after F+360), required 0", tail_bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    int          offs [4] = '{5, 25, 145, 165};
    logic [7:0]  exps [4] = '{8'd28, 8'd228, 8'd28, 8'd28};
    bit          found;
    int          edges;
    bus.sender_ad = 8'h33;
    bus.sender_sync_in = 1'b1;
    wait_frame(10, found, edges);
    for (int off = 1; off <= 200; off++) begin
      tick();
      if (off == 195) begin
        tests_run++;
        if (bus.sender_da !== 8'd228) begin
          tests_failed++;
          $display("FAIL midreset_pre@F+195: got %0d required 228", bus.sender_da);
        end
      end
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.sender_da !== 8'h80 || bus.sender_sync_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async: got da=%h sync=%b required da=80 sync=0",
               bus.sender_da, bus.sender_sync_out);
    end
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    wait_frame(10, found, edges);
    tests_run++;
    if (edges < 3 || edges > 4) begin
      tests_failed++;
      $display("FAIL midreset_restart: frame started %0d edges after release, required 3..4", edges);
    end
    for (int off = 1; off <= 165; off++) begin
      tick();
      for (int j = 0; j < 4; j++) begin
        if (off == offs[j]) begin
          tests_run++;
          if (bus.sender_da !== exps[j]) begin
            tests_failed++;
            $display("FAIL midreset_fresh@F+%0d: got %0d required %0d", off, bus.sender_da, exps[j]);
          end
        end
      end
    end
    bus.sender_sync_in = 1'b0;
  endtask

  initial begin
    bus.sender_sync_in = 1'b0;
    bus.sender_ad = 8'h00;
    test_reset();
    test_idle();
    test_single_frame();
    test_continuous();
    test_mid_disable();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (required normal completion)");
    $fatal(1, "watchdog");
  end

endmodule
